// File: rtl/noise_step_ctrl.sv
// noise_step_ctrl
//   Sequencer for the shared noise LFSR. The master clock is divided by PRESCALE
//   and then by the programmed noise period; every other period boundary emits a
//   single-cycle shift_en strobe to the external LFSR. Configuration (period,
//   channel mask, enable) arrives over a valid/ready port. While running, a write
//   is parked in a one-deep pending slot and takes effect only on a period
//   boundary, so the strobe cadence never glitches. The LFSR output bit is gated
//   onto per-channel noise lines for an AND-style mixer.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   cfg_valid   in   config write request
//   cfg_ready   out  pending slot free; transfer on cfg_valid & cfg_ready
//   cfg_period  in   noise period (0 behaves as 1)
//   cfg_mask    in   per-channel noise enable
//   cfg_enable  in   0 = stop sequencing and return to IDLE
//   lfsr_bit    in   current LFSR output bit
//   shift_en    out  one-cycle strobe: LFSR shifts on this edge
//   busy        out  high while running
//   noise_ch    out  lfsr_bit where mask bit set, else 1
module noise_step_ctrl #(
  parameter int PERIOD_BITS = 5,
  parameter int CHANNELS    = 3,
  parameter int PRESCALE    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [CHANNELS-1:0]    cfg_mask,
  input  logic                   cfg_enable,
  input  logic                   lfsr_bit,
  output logic                   shift_en,
  output logic                   busy,
  output logic [CHANNELS-1:0]    noise_ch
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t                 state,        state_nxt;
  logic [PS_W-1:0]        ps_cnt,       ps_cnt_nxt;
  logic [PERIOD_BITS-1:0] per_cnt,      per_cnt_nxt;
  logic                   phase,        phase_nxt;
  logic [PERIOD_BITS-1:0] act_period,   act_period_nxt;
  logic [CHANNELS-1:0]    act_mask,     act_mask_nxt;
  logic                   pending,      pending_nxt;
  logic [PERIOD_BITS-1:0] pend_period,  pend_period_nxt;
  logic [CHANNELS-1:0]    pend_mask,    pend_mask_nxt;
  logic                   pend_enable,  pend_enable_nxt;
  logic                   shift_en_nxt;

  logic [PERIOD_BITS-1:0] eff_last;
  logic                   tick;
  logic                   boundary;
  logic                   accept;

  // Last period-counter value before a boundary; a zero period behaves as 1.
  assign eff_last = (act_period == '0) ? '0 : act_period - 1'b1;
  assign tick     = (ps_cnt == PS_LAST);
  assign boundary = (state == RUN) && tick && (per_cnt == eff_last);

  // cfg_ready comes straight from the pending flag so it never depends on cfg_valid.
  assign cfg_ready = ~pending;
  assign accept    = cfg_valid & cfg_ready;
  assign busy      = (state == RUN);

  // Unmasked channels sit at 1 so they are neutral in the AND mixer.
  assign noise_ch = (act_mask & {CHANNELS{lfsr_bit}}) | ~act_mask;

  always_comb begin
    state_nxt       = state;
    ps_cnt_nxt      = ps_cnt;
    per_cnt_nxt     = per_cnt;
    phase_nxt       = phase;
    act_period_nxt  = act_period;
    act_mask_nxt    = act_mask;
    pending_nxt     = pending;
    pend_period_nxt = pend_period;
    pend_mask_nxt   = pend_mask;
    pend_enable_nxt = pend_enable;
    shift_en_nxt    = 1'b0;

    unique case (state)
      IDLE: begin
        ps_cnt_nxt  = '0;
        per_cnt_nxt = '0;
        phase_nxt   = 1'b0;
        // In IDLE a config takes effect at once; a disable write is simply consumed.
        if (accept && cfg_enable) begin
          act_period_nxt = cfg_period;
          act_mask_nxt   = cfg_mask;
          state_nxt      = RUN;
        end
      end

      RUN: begin
        ps_cnt_nxt = tick ? '0 : ps_cnt + 1'b1;
        if (boundary) begin
          per_cnt_nxt = '0;
        end else if (tick) begin
          per_cnt_nxt = per_cnt + 1'b1;
        end

        if (boundary) begin
          phase_nxt    = ~phase;
          shift_en_nxt = ~phase;
          // The pending write lands here; phase and prescaler keep running so the
          // strobe spacing carries straight across the change.
          if (pending) begin
            pending_nxt    = 1'b0;
            act_period_nxt = pend_period;
            act_mask_nxt   = pend_mask;
            if (!pend_enable) begin
              // The strobe from this boundary still goes out via shift_en_nxt.
              state_nxt    = IDLE;
              ps_cnt_nxt   = '0;
              per_cnt_nxt  = '0;
              phase_nxt    = 1'b0;
              act_mask_nxt = '0;
            end
          end
        end

        // accept implies pending==0, so this never collides with the apply above;
        // a write landing on a boundary waits for the following one.
        if (accept) begin
          pending_nxt     = 1'b1;
          pend_period_nxt = cfg_period;
          pend_mask_nxt   = cfg_mask;
          pend_enable_nxt = cfg_enable;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ps_cnt      <= '0;
      per_cnt     <= '0;
      phase       <= 1'b0;
      act_period  <= '0;
      act_mask    <= '0;
      pending     <= 1'b0;
      pend_period <= '0;
      pend_mask   <= '0;
      pend_enable <= 1'b0;
      shift_en    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ps_cnt      <= ps_cnt_nxt;
      per_cnt     <= per_cnt_nxt;
      phase       <= phase_nxt;
      act_period  <= act_period_nxt;
      act_mask    <= act_mask_nxt;
      pending     <= pending_nxt;
      pend_period <= pend_period_nxt;
      pend_mask   <= pend_mask_nxt;
      pend_enable <= pend_enable_nxt;
      shift_en    <= shift_en_nxt;
    end
  end

endmodule

// File: tb/tb_noise_step_ctrl.sv
// tb_noise_step_ctrl
//   Directed bench for noise_step_ctrl with PERIOD_BITS=5, CHANNELS=3, PRESCALE=16.
//   Inputs change and outputs are sampled 1 time unit after each rising edge;
//   cyc counts rising edges since the start of the run.
module tb_noise_step_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_period;
  logic [2:0] cfg_mask;
  logic       cfg_enable;
  logic       lfsr_bit;
  logic       shift_en;
  logic       busy;
  logic [2:0] noise_ch;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int acc, prev, at, cnt, xfers;

  noise_step_ctrl #(
    .PERIOD_BITS(5),
    .CHANNELS   (3),
    .PRESCALE   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_mask  (cfg_mask),
    .cfg_enable(cfg_enable),
    .lfsr_bit  (lfsr_bit),
    .shift_en  (shift_en),
    .busy      (busy),
    .noise_ch  (noise_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // One-cycle write; the accept edge is the one this task steps across.
  task automatic do_cfg(input logic [4:0] p, input logic [2:0] m, input logic en);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_mask   = m;
    cfg_enable = en;
    check("cfg_ready_at_write", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
  endtask

  // Returns the cycle of the next shift_en, or -1 if none within max cycles.
  task automatic wait_strobe(input int max, output int when);
    when = -1;
    for (int k = 0; k < max; k++) begin
      step();
      if (shift_en) begin
        when = cyc;
        break;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_mask   = '0;
    cfg_enable = 1'b0;
    lfsr_bit   = 1'b0;
    steps(3);

    check("rst_shift_en", shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_noise_ch", noise_ch, 3'b111);
    reset = 1'b0;
    step();

    // Period 1, mask 101: first strobe 16 after accept, then every 32.
    do_cfg(5'd1, 3'b101, 1'b1);
    acc = cyc;
    check("t1_busy", busy, 1);
    wait_strobe(40, at);
    check("t1_first_gap", at - acc, 16);
    prev = at;
    check("t1_noise_lfsr0", noise_ch, 3'b010);
    lfsr_bit = 1'b1;
    #1;
    check("t1_noise_lfsr1", noise_ch, 3'b111);
    lfsr_bit = 1'b0;
    wait_strobe(40, at);
    check("t1_gap2", at - prev, 32);
    prev = at;
    wait_strobe(40, at);
    check("t1_gap3", at - prev, 32);
    prev = at;

    // Disable written after the silent boundary: final strobe then IDLE.
    steps(20);
    do_cfg(5'd1, 3'b101, 1'b0);
    check("t4_ready_low", cfg_ready, 0);
    check("t4_busy_still", busy, 1);
    wait_strobe(40, at);
    check("t4_final_gap", at - prev, 32);
    check("t4_busy_off", busy, 0);
    check("t4_ready_back", cfg_ready, 1);
    check("t4_noise_neutral", noise_ch, 3'b111);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (shift_en) cnt++;
    end
    check("t4_no_strobes", cnt, 0);
    check("t4_idle_busy", busy, 0);

    // Period 0 behaves as period 1.
    do_cfg(5'd0, 3'b010, 1'b1);
    acc = cyc;
    wait_strobe(40, at);
    check("t2_p0_first_gap", at - acc, 16);
    check("t2_noise_mask010", noise_ch, 3'b101);
    prev = at;
    wait_strobe(40, at);
    check("t2_p0_gap", at - prev, 32);
    prev = at;

    // Period 31, applied on the silent boundary 16 later: next strobe 16+496, then 992.
    do_cfg(5'd31, 3'b111, 1'b1);
    check("t2_pending_ready", cfg_ready, 0);
    wait_strobe(600, at);
    check("t2_p31_first_gap", at - prev, 512);
    check("t2_noise_mask111", noise_ch, 3'b000);
    prev = at;
    wait_strobe(1100, at);
    check("t2_p31_gap", at - prev, 992);
    prev = at;

    // Period 2 applied at the silent boundary 496 later, strobe 32 after that.
    do_cfg(5'd2, 3'b100, 1'b1);
    wait_strobe(600, at);
    check("t3_p2_first_gap", at - prev, 528);
    prev = at;
    wait_strobe(80, at);
    check("t3_p2_gap", at - prev, 64);
    prev = at;

    // Period 4 written mid-interval: 64 stays, then 128.
    steps(40);
    do_cfg(5'd4, 3'b100, 1'b1);
    check("t3_ready_low", cfg_ready, 0);
    wait_strobe(80, at);
    check("t3_gap_before_apply", at - prev, 64);
    check("t3_ready_after_apply", cfg_ready, 1);
    prev = at;
    wait_strobe(200, at);
    check("t3_p4_gap", at - prev, 128);
    prev = at;
    check("t5_noise_start", noise_ch, 3'b011);

    // cfg_valid held high with mask changing every cycle; period stays 4.
    xfers = 0;
    for (int i = 0; i < 140; i++) begin
      cfg_valid  = 1'b1;
      cfg_period = 5'd4;
      cfg_enable = 1'b1;
      cfg_mask   = 3'((i % 7) + 1);
      if (cfg_ready) xfers++;
      step();
      if (i == 62) begin
        check("t5_noise_before_bnd", noise_ch, 3'b011);
        check("t5_ready_held_low", cfg_ready, 0);
      end
      if (i == 63) begin
        check("t5_noise_mask1", noise_ch, 3'b110);
        check("t5_no_strobe_silent", shift_en, 0);
        check("t5_ready_after_bnd", cfg_ready, 1);
      end
      if (i == 127) begin
        check("t5_strobe_128", shift_en, 1);
        check("t5_noise_mask2", noise_ch, 3'b101);
      end
    end
    cfg_valid = 1'b0;
    check("t5_transfers", xfers, 3);
    check("t5_pending_end", cfg_ready, 0);

    // Reset with a write pending: it must be dropped.
    reset = 1'b1;
    step();
    check("t6_busy", busy, 0);
    check("t6_ready", cfg_ready, 1);
    check("t6_shift_en", shift_en, 0);
    check("t6_noise", noise_ch, 3'b111);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (shift_en || busy || noise_ch != 3'b111) cnt++;
    end
    check("t6_pending_dropped", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
